// File: rtl/bcd_decade_sequencer_if.sv
// Control/display bundle for the decade sequencer: lab inputs in, BCD digit and
// active-low lamp decode out.
interface bcd_decade_sequencer_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic [9:0] y_n;
  logic       tc;
  logic       load_err;

  modport master (
    output en, up, load, load_val,
    input  bcd, y_n, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, y_n, tc, load_err
  );
endinterface

// File: rtl/bcd_decade_sequencer.sv
// Prescaled up/down BCD decade counter with registered active-low decimal
// decode, validated synchronous load and a terminal-count pulse for cascading.
module bcd_decade_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_decade_sequencer_if.slave  bus
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic {HOLD, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bcd_q;
  logic [9:0]       y_n_q;
  logic             tc_q;
  logic             load_err_q;

  logic             valid_load;
  logic             step;
  logic             wrap;
  logic [3:0]       bcd_next;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    valid_load = bus.load && (bus.load_val <= 4'd9);
    step       = bus.en && !valid_load && (div_cnt == DIV_MAX);
    wrap       = 1'b0;
    bcd_next   = bcd_q;

    if (valid_load) begin
      bcd_next = bus.load_val;
    end else if (step) begin
      if (bus.up) begin
        wrap     = (bcd_q == 4'd9);
        bcd_next = wrap ? 4'd0 : bcd_q + 4'd1;
      end else begin
        wrap     = (bcd_q == 4'd0);
        bcd_next = wrap ? 4'd9 : bcd_q - 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HOLD;
      div_cnt    <= '0;
      bcd_q      <= 4'd0;
      y_n_q      <= 10'h3FE;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      // The mode register only tracks enable/load history; the prescaler
      // itself is qualified directly by en so the first step lands exactly
      // TICK_DIV enabled cycles after div_cnt was last cleared.
      if (valid_load) begin
        state <= HOLD;
      end else begin
        case (state)
          HOLD:    if (bus.en)  state <= RUN;
          RUN:     if (!bus.en) state <= HOLD;
          default: state <= HOLD;
        endcase
      end

      if (valid_load) begin
        div_cnt <= '0;
      end else if (bus.en) begin
        div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
      end

      // Decode from the next digit so bcd and y_n switch on the same edge.
      bcd_q      <= bcd_next;
      y_n_q      <= ~(10'd1 << bcd_next);
      tc_q       <= wrap;
      load_err_q <= bus.load && !valid_load;
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.y_n      = y_n_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule
